// File: rtl/sga_interface_direcao.sv
// Turn-command front end: synchronises and debounces the turn buttons and latches presses over a measurement window.
// Optional macro SGA_HOLD_PRESS_EN: a button already held when a window opens counts as a press for that window.
module sga_interface_direcao #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WINDOW_CYCLES   = 5000000
) (
  input  logic       clock,
  input  logic       restart,
  input  logic       reset_interface,
  input  logic       medir,
  input  logic       conta_inter,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] interface_direction,
  output logic       fim_inter,
  output logic [1:0] db_estado
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    JANELA = 2'b01,
    FIM    = 2'b10
  } state_t;

  // Index 0 is the left button, index 1 the right, matching {dir, esq}.
  logic [1:0]                  btn_s;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [1:0]                  lvl_q, lvl_d, lvl_prev_q;
  logic [1:0]                  press_s;
  logic [1:0]                  entry_flags_s;

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [1:0]        flag_q, flag_d;
  logic [1:0]        dir_q, dir_d;
  logic              fim_q, fim_d;
  logic [1:0]        estado_q, estado_d;

  assign btn_s   = {btn_right, btn_left};
  assign press_s = lvl_q & ~lvl_prev_q;

`ifdef SGA_HOLD_PRESS_EN
  assign entry_flags_s = lvl_q;
`else
  assign entry_flags_s = 2'b00;
`endif

  // Synchroniser shift and debounce counter for both buttons.
  always_comb begin
    sync_d   = sync_q;
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_s[i]};
      if (sync_q[i][SYNC_STAGES-1] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i]    = sync_q[i][SYNC_STAGES-1];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Button conditioning registers.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      lvl_q      <= 2'b00;
      lvl_prev_q <= 2'b00;
    end else begin
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  // Window state machine: next state, counter, flags and result load.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    flag_d    = flag_q;
    dir_d     = dir_q;
    if (reset_interface) begin
      state_d   = IDLE;
      win_cnt_d = '0;
      flag_d    = 2'b00;
      dir_d     = 2'b00;
    end else begin
      case (state_q)
        IDLE, FIM: begin
          if (medir) begin
            state_d   = JANELA;
            win_cnt_d = '0;
            flag_d    = entry_flags_s;
          end else begin
            state_d   = state_q;
          end
        end
        JANELA: begin
          flag_d = flag_q | press_s;
          if (conta_inter) begin
            // Include a press landing on the last counted cycle.
            if (win_cnt_q == WIN_LAST) begin
              state_d   = FIM;
              win_cnt_d = '0;
              dir_d     = flag_q | press_s;
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q;
          end
        end
        default: begin
          state_d   = IDLE;
          win_cnt_d = '0;
          flag_d    = 2'b00;
          dir_d     = 2'b00;
        end
      endcase
    end
    fim_d    = (state_d == FIM);
    estado_d = state_d;
  end

  // Window state and output registers.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      flag_q    <= 2'b00;
      dir_q     <= 2'b00;
      fim_q     <= 1'b0;
      estado_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      flag_q    <= flag_d;
      dir_q     <= dir_d;
      fim_q     <= fim_d;
      estado_q  <= estado_d;
    end
  end

  assign interface_direction = dir_q;
  assign fim_inter           = fim_q;
  assign db_estado           = estado_q;

endmodule

// File: tb/tb_sga_interface_direcao.sv
// Directed self-checking bench for sga_interface_direcao (SYNC=2, DEBOUNCE=4, WINDOW=20).
module tb_sga_interface_direcao;

  logic       clock;
  logic       restart;
  logic       reset_interface;
  logic       medir;
  logic       conta_inter;
  logic       btn_left;
  logic       btn_right;
  logic [1:0] interface_direction;
  logic       fim_inter;
  logic [1:0] db_estado;

  int n_cmp;
  int n_fail;

  sga_interface_direcao #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .WINDOW_CYCLES  (20)
  ) dut (
    .clock              (clock),
    .restart            (restart),
    .reset_interface    (reset_interface),
    .medir              (medir),
    .conta_inter        (conta_inter),
    .btn_left           (btn_left),
    .btn_right          (btn_right),
    .interface_direction(interface_direction),
    .fim_inter          (fim_inter),
    .db_estado          (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cycle(input int k, input int l_start, input int l_len,
                             input int r_start, input int r_len, input bit r_tog,
                             input int c_start, input int c_len);
    bit in_r;
    btn_left    = (k >= l_start) && (k < l_start + l_len);
    in_r        = (k >= r_start) && (k < r_start + r_len);
    btn_right   = r_tog ? (in_r && (k % 2 == 0)) : in_r;
    conta_inter = !((k >= c_start) && (k < c_start + c_len));
  endtask

  // Pulses medir, scripts the buttons per window cycle and waits (bounded) for fim_inter.
  task automatic run_window(input int l_start, input int l_len,
                            input int r_start, input int r_len, input bit r_tog,
                            input int c_start, input int c_len,
                            output int ticks, output logic [1:0] dir_m,
                            output logic fim_m, output logic [1:0] est_m);
    drive_cycle(0, l_start, l_len, r_start, r_len, r_tog, c_start, c_len);
    medir = 1'b1;
    tick();
    medir = 1'b0;
    ticks = 1;
    dir_m = interface_direction;
    fim_m = fim_inter;
    est_m = db_estado;
    while (fim_inter !== 1'b1 && ticks < 100) begin
      drive_cycle(ticks, l_start, l_len, r_start, r_len, r_tog, c_start, c_len);
      tick();
      ticks++;
    end
    conta_inter = 1'b1;
  endtask

  task automatic test_reset();
    restart = 1'b1; reset_interface = 1'b0; medir = 1'b0;
    conta_inter = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick(); tick();
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b want 00", interface_direction); end
    n_cmp++; if (fim_inter !== 1'b0) begin n_fail++; $display("FAIL reset_fim: got %b want 0", fim_inter); end
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL reset_estado: got %b want 00", db_estado); end
    restart = 1'b0;
    tick();
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL reset_release_estado: got %b want 00", db_estado); end
  endtask

  task automatic test_left_press();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    run_window(3, 10, 0, 0, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (e !== 2'b01) begin n_fail++; $display("FAIL left_medir_latency: got estado %b want 01", e); end
    n_cmp++; if (t !== 21) begin n_fail++; $display("FAIL left_fim_latency: got %0d want 21", t); end
    n_cmp++; if (interface_direction !== 2'b01) begin n_fail++; $display("FAIL left_result: got %b want 01", interface_direction); end
    n_cmp++; if (db_estado !== 2'b10) begin n_fail++; $display("FAIL left_estado_fim: got %b want 10", db_estado); end
  endtask

  task automatic test_bounce();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    run_window(0, 0, 3, 12, 1'b1, 0, 0, t, d, f, e);
    n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL bounce_fim_drop: got %b want 0", f); end
    n_cmp++; if (d !== 2'b01) begin n_fail++; $display("FAIL bounce_dir_hold: got %b want 01", d); end
    n_cmp++; if (t !== 21) begin n_fail++; $display("FAIL bounce_fim_latency: got %0d want 21", t); end
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL bounce_result: got %b want 00", interface_direction); end
  endtask

  task automatic test_both();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    run_window(2, 8, 4, 8, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (interface_direction !== 2'b11) begin n_fail++; $display("FAIL both_result: got %b want 11", interface_direction); end
    run_window(0, 0, 0, 0, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL both_next_fim_drop: got %b want 0", f); end
    n_cmp++; if (d !== 2'b11) begin n_fail++; $display("FAIL both_next_dir_hold: got %b want 11", d); end
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL both_next_result: got %b want 00", interface_direction); end
  endtask

  task automatic test_hold();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    logic [1:0] exp_second;
`ifdef SGA_HOLD_PRESS_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b00;
`endif
    run_window(0, 0, 3, 1000, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (interface_direction !== 2'b10) begin n_fail++; $display("FAIL hold_first_result: got %b want 10", interface_direction); end
    run_window(0, 0, 0, 1000, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (interface_direction !== exp_second) begin n_fail++; $display("FAIL hold_second_result: got %b want %b", interface_direction, exp_second); end
    btn_right = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_conta_gap();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    run_window(3, 10, 0, 0, 1'b0, 5, 15, t, d, f, e);
    n_cmp++; if (t !== 36) begin n_fail++; $display("FAIL gap_fim_latency: got %0d want 36", t); end
    n_cmp++; if (interface_direction !== 2'b01) begin n_fail++; $display("FAIL gap_result: got %b want 01", interface_direction); end
    reset_interface = 1'b1; medir = 1'b1;
    tick();
    reset_interface = 1'b0; medir = 1'b0;
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL rstif_dir: got %b want 00", interface_direction); end
    n_cmp++; if (fim_inter !== 1'b0) begin n_fail++; $display("FAIL rstif_fim: got %b want 0", fim_inter); end
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL rstif_estado: got %b want 00", db_estado); end
    tick();
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL rstif_stays_idle: got %b want 00", db_estado); end
  endtask

  task automatic test_restart_mid();
    int t; logic [1:0] d; logic f; logic [1:0] e;
    run_window(3, 10, 0, 0, 1'b0, 0, 0, t, d, f, e);
    n_cmp++; if (interface_direction !== 2'b01) begin n_fail++; $display("FAIL mid_pre_result: got %b want 01", interface_direction); end
    medir = 1'b1;
    tick();
    medir = 1'b0;
    repeat (5) tick();
    n_cmp++; if (db_estado !== 2'b01) begin n_fail++; $display("FAIL mid_in_window: got %b want 01", db_estado); end
    restart = 1'b1;
    #2;
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL mid_async_dir: got %b want 00", interface_direction); end
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL mid_async_estado: got %b want 00", db_estado); end
    restart = 1'b0;
    tick();
    n_cmp++; if (interface_direction !== 2'b00) begin n_fail++; $display("FAIL mid_after_dir: got %b want 00", interface_direction); end
    n_cmp++; if (fim_inter !== 1'b0) begin n_fail++; $display("FAIL mid_after_fim: got %b want 0", fim_inter); end
    n_cmp++; if (db_estado !== 2'b00) begin n_fail++; $display("FAIL mid_after_estado: got %b want 00", db_estado); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_left_press();
    test_bounce();
    test_both();
    test_hold();
    test_conta_gap();
    test_restart_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
